fir_param: RTL and testbench
============================

Name: fir_param

Overview:
Parametrised direct-form FIR filter, successor to the fixed 9-bit/11-tap FILTER. Tap count, data width and output pipeline depth are generics. Coefficients load through a double-buffered write port instead of one bus per tap. The output is saturated. The block drops into the existing clk_gen/data_maker/data_sink bench flow via the unchanged CLK/RST_n/DIN/VIN/DOUT/VOUT handshake.

Parameters:
NB, 9, data and coefficient width, signed two's complement Q1.(NB-1), legal 4..16
NT, 11, number of taps (filter order NT-1), legal 2..32
PIPE, 1, register stages between delay line and DOUT, legal 1..4
AB, 4, coefficient address width, must satisfy 2^AB >= NT

Ports:
CLK  in  1  clock, all state on rising edge
RST_n  in  1  asynchronous active-low reset
DIN  in  NB  input sample, signed
VIN  in  1  DIN valid, one sample accepted per cycle with VIN=1
COEF_WE  in  1  write COEF_DIN into shadow coefficient COEF_ADDR
COEF_ADDR  in  AB  shadow coefficient index 0..NT-1
COEF_DIN  in  NB  coefficient value, signed
COEF_COMMIT  in  1  copy entire shadow bank into active bank
CLR  in  1  synchronous flush of delay line and in-flight results
DOUT  out  NB  filtered sample, signed, saturated
VOUT  out  1  DOUT valid, one-cycle pulse per result

Behaviour:
- Reset (async, RST_n=0): delay line x[0..NT-1]=0, shadow and active banks=0, all pipeline data/valid=0, DOUT=0, VOUT=0. Reset mid-operation discards in-flight results; no VOUT pulse follows for them.
- Delay line: on edge with VIN=1: x[0]<=DIN, x[i]<=x[i-1]. With VIN=0 the delay line holds.
- Arithmetic: y = sum over i of b[i]*x[i] using the active bank. Accumulate at full precision, signed, width 2*NB+ceil(log2 NT), no intermediate truncation. Scale by arithmetic shift right NB-1 (floor, not round). Saturate to [-2^(NB-1), 2^(NB-1)-1].
- Pipeline: products/sum are computed from the updated delay line and pass through PIPE register stages. The pipeline never stalls. valid enters with VIN and travels alongside the data.
- Latency: sample accepted at edge k gives VOUT=1 and its DOUT during the cycle after edge k+PIPE. Back-to-back VIN gives back-to-back VOUT.
- DOUT holds its last valid value while VOUT=0.
- Coefficient write: COEF_WE=1 writes shadow[COEF_ADDR] on the edge. COEF_ADDR>=NT is ignored; no state changes.
- Commit: on an edge with COEF_COMMIT=1, active<=shadow, all taps atomically.
  - A sample accepted on that same edge is computed with the OLD active bank; the new bank applies from the next accepted sample.
  - If COEF_WE and COEF_COMMIT are high together, the committed value for that address is the value being written (write-through to active).
  - Results already in the pipeline are unaffected by a commit.
- CLR=1: delay line zeroed and all pipeline valid bits cleared on that edge; no VOUT for flushed samples. Coefficients are retained.
  - A VIN in the same cycle as CLR is dropped.
  - CLR has priority over VIN. COEF_WE/COEF_COMMIT still act during CLR.
- Only the active bank feeds the datapath. Shadow writes never alter DOUT until committed.

Test Plan:
1. Impulse, NB=9 NT=11 PIPE=1: load b[i]=10*(i+1), commit, DIN=255 once then 0 x11. Expected DOUT sequence = floor(255*b[i]/256) = 9,19,29,39,49,59,69,79,89,99,109. Each VOUT arrives 2 edges after its VIN.
2. Saturation: all b[i]=64, step DIN=100 on every cycle. DOUT=25,50,...,250, then 255 (positive clip) from the 11th sample. Repeat with DIN=-100: -25,...,-250, then -256.
3. Floor and corner: b0=-256, others 0, DIN=-256 gives 255 (saturated). b0=1, DIN=-1 gives -1. b0=1, DIN=1 gives 0.
4. Commit timing: active b0=64, shadow b0=128. Assert COEF_COMMIT on the same edge as VIN with DIN=100: that result is 25; the next accepted DIN=100 gives 50. A write to COEF_ADDR=11..15 changes nothing.
5. Gapped VIN and CLR: VIN pattern 1,0,0,1,1 yields exactly 3 VOUT pulses, each PIPE+1 edges after its VIN, with DOUT held between pulses. Asserting CLR while 2 results are in flight gives no VOUT for them, and the next impulse response starts from a zero delay line.
6. Reset mid-stream and parameter sweep: drop RST_n asynchronously between edges. DOUT=0 and VOUT=0 immediately, and coefficients read back as 0 (impulse gives DOUT=0). Rerun test 1 with NB=12, NT=4, PIPE=3 and confirm 4-edge latency.

Source files
------------

// File: rtl/fir_param.sv
// Parametrised direct-form FIR with double-buffered coefficients and saturated output.
// Sample accepted at edge k appears on DOUT/VOUT after edge k+PIPE; never stalls.
module fir_param #(
  parameter int NB   = 9,
  parameter int NT   = 11,
  parameter int PIPE = 1,
  parameter int AB   = 4
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic [NB-1:0] DIN,
  input  logic          VIN,
  input  logic          COEF_WE,
  input  logic [AB-1:0] COEF_ADDR,
  input  logic [NB-1:0] COEF_DIN,
  input  logic          COEF_COMMIT,
  input  logic          CLR,
  output logic [NB-1:0] DOUT,
  output logic          VOUT
);

  localparam int AW = 2*NB + $clog2(NT);
  localparam logic signed [AW-1:0] SMAX = AW'((1 << (NB-1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  logic signed [NB-1:0]   x      [NT];
  logic signed [NB-1:0]   x_nxt  [NT];
  logic signed [NB-1:0]   shadow [NT];
  logic signed [NB-1:0]   active [NT];
  logic signed [2*NB-1:0] prod   [NT];
  logic signed [AW-1:0]   acc_nxt;
  logic signed [AW-1:0]   acc;
  logic                   acc_vld;
  logic signed [AW-1:0]   scaled;
  logic [NB-1:0]          sat;
  logic [NB-1:0]          pd     [PIPE];
  logic                   pv     [PIPE];
  logic [NB-1:0]          sd_in  [PIPE];
  logic                   sv_in  [PIPE];

  // The sum is formed from the post-shift delay line and the pre-commit bank,
  // so a sample accepted on a commit edge still sees the old coefficients.
  always_comb begin
    x_nxt[0] = DIN;
    for (int i = 1; i < NT; i++) x_nxt[i] = x[i-1];
    acc_nxt = '0;
    for (int i = 0; i < NT; i++) begin
      prod[i] = (2*NB)'(x_nxt[i]) * (2*NB)'(active[i]);
      acc_nxt = acc_nxt + AW'(prod[i]);
    end
  end

  always_comb begin
    scaled = acc >>> (NB-1);
    if (scaled > SMAX)      sat = SMAX[NB-1:0];
    else if (scaled < SMIN) sat = SMIN[NB-1:0];
    else                    sat = scaled[NB-1:0];
  end

  always_comb begin
    for (int j = 0; j < PIPE; j++) begin
      sd_in[j] = (j == 0) ? sat : pd[(j == 0) ? 0 : j-1];
      sv_in[j] = (j == 0) ? acc_vld : pv[(j == 0) ? 0 : j-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NT; i++) begin
        x[i]      <= '0;
        shadow[i] <= '0;
        active[i] <= '0;
      end
      acc     <= '0;
      acc_vld <= 1'b0;
      for (int j = 0; j < PIPE; j++) begin
        pd[j] <= '0;
        pv[j] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (CLR)      x[i] <= '0;
        else if (VIN) x[i] <= x_nxt[i];
        if (COEF_WE && COEF_ADDR == AB'(i)) shadow[i] <= COEF_DIN;
        if (COEF_COMMIT)
          active[i] <= (COEF_WE && COEF_ADDR == AB'(i)) ? COEF_DIN : shadow[i];
      end
      acc     <= acc_nxt;
      acc_vld <= VIN && !CLR;
      // The final stage only loads on a real result so DOUT holds between pulses.
      for (int j = 0; j < PIPE; j++) begin
        pv[j] <= sv_in[j] && !CLR;
        if (j < PIPE-1 || (sv_in[j] && !CLR)) pd[j] <= sd_in[j];
      end
    end
  end

  assign DOUT = pd[PIPE-1];
  assign VOUT = pv[PIPE-1];

endmodule

// File: tb/tb_fir_param.sv
// Bench for fir_param: scoreboard against an integer reference model plus directed corner sequences.
module tb_fir_param;

  localparam int NTA = 11;
  localparam int PA  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   t_din = 0, t_cdin = 0, t_addr = 0;
  logic t_vin = 0, t_we = 0, t_commit = 0, t_clr = 0;
  logic [8:0] a_dout;
  logic       a_vout;

  fir_param #(.NB(9), .NT(11), .PIPE(1), .AB(4)) dut_a (
    .CLK(clk), .RST_n(rst_n), .DIN(9'(t_din)), .VIN(t_vin),
    .COEF_WE(t_we), .COEF_ADDR(4'(t_addr)), .COEF_DIN(9'(t_cdin)),
    .COEF_COMMIT(t_commit), .CLR(t_clr), .DOUT(a_dout), .VOUT(a_vout));

  int   b_din = 0, b_cdin = 0, b_addr = 0;
  logic b_vin = 0, b_we = 0, b_commit = 0, b_clr = 0;
  logic [11:0] b_dout;
  logic        b_vout;

  fir_param #(.NB(12), .NT(4), .PIPE(3), .AB(2)) dut_b (
    .CLK(clk), .RST_n(rst_n), .DIN(12'(b_din)), .VIN(b_vin),
    .COEF_WE(b_we), .COEF_ADDR(2'(b_addr)), .COEF_DIN(12'(b_cdin)),
    .COEF_COMMIT(b_commit), .CLR(b_clr), .DOUT(b_dout), .VOUT(b_vout));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: integer history, banks, and a queue of expected results with due edges.
  typedef struct { int val; int due; } exp_t;
  int   hist [NTA];
  int   act  [NTA];
  int   shd  [NTA];
  exp_t q    [$];
  int   seen [$];
  int   edge_n = 0;
  int   last = 0;

  function automatic int floor_div(input longint y, input longint d);
    longint r;
    r = y / d;
    if ((y % d != 0) && (y < 0)) r = r - 1;
    return int'(r);
  endfunction

  function automatic int clip(input int v);
    return (v > 255) ? 255 : (v < -256) ? -256 : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NTA; i++) begin hist[i] = 0; act[i] = 0; shd[i] = 0; end
    q.delete();
    last = 0;
  endfunction

  function automatic void model_edge();
    longint y;
    edge_n++;
    if (t_clr)
      while (q.size() > 0 && q[$].due >= edge_n) void'(q.pop_back());
    if (t_vin && !t_clr) begin
      for (int i = NTA-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = t_din;
      y = 0;
      for (int i = 0; i < NTA; i++) y += longint'(hist[i]) * longint'(act[i]);
      q.push_back('{clip(floor_div(y, 256)), edge_n + PA});
    end
    if (t_clr) for (int i = 0; i < NTA; i++) hist[i] = 0;
    if (t_we && t_addr < NTA) shd[t_addr] = t_cdin;
    if (t_commit) act = shd;
  endfunction

  task automatic model_check();
    int ev, ed, got;
    if (q.size() > 0 && q[0].due == edge_n) begin
      ev = 1; ed = q[0].val; last = ed; void'(q.pop_front());
    end else begin
      ev = 0; ed = last;
    end
    got = $signed(a_dout);
    chk("vout", int'(a_vout), ev);
    chk("dout", got, ed);
    if (a_vout) seen.push_back(got);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin edge_n++; model_reset(); end
    else model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input int n);
    t_vin = 0; t_we = 0; t_commit = 0; t_clr = 0;
    repeat (n) step();
  endtask

  task automatic clear();
    t_clr = 1; step(); t_clr = 0;
  endtask

  task automatic set_coef(input int a, input int v, input logic cm);
    t_we = 1; t_addr = a; t_cdin = v; t_commit = cm;
    step();
    t_we = 0; t_commit = 0;
  endtask

  task automatic sample(input int d);
    t_vin = 1; t_din = d; step(); t_vin = 0;
  endtask

  function automatic int seen_at(input int i);
    return (i < seen.size()) ? seen[i] : 99999;
  endfunction

  typedef struct { int b0; int din; int exp; } vec_t;
  vec_t corner [7];
  int   imp_exp [11];
  int   b_exp   [4];

  initial begin
    corner[0] = '{-256, -256,  255};
    corner[1] = '{   1,   -1,   -1};
    corner[2] = '{   1,    1,    0};
    corner[3] = '{ 255,  255,  254};
    corner[4] = '{-256,  255, -255};
    corner[5] = '{ 255, -256, -255};
    corner[6] = '{-256,    1,   -1};
    imp_exp = '{9, 19, 29, 39, 49, 59, 69, 79, 89, 99, 109};
    b_exp   = '{9, 19, 29, 39};
    model_reset();

    #1;
    chk("reset_dout", int'(a_dout), 0);
    chk("reset_vout", int'(a_vout), 0);
    @(negedge clk);
    rst_n = 1;

    // Impulse response through the 11-tap bank
    for (int i = 0; i < NTA; i++) set_coef(i, 10*(i+1), 1'(i == NTA-1));
    clear();
    seen.delete();
    sample(255);
    repeat (10) sample(0);
    idle(3);
    chk("imp_count", seen.size(), 11);
    for (int i = 0; i < 11; i++) chk("imp_val", seen_at(i), imp_exp[i]);

    // Gapped VIN, then CLR with results in flight
    clear();
    seen.delete();
    foreach (imp_exp[i]) if (i < 5) begin
      t_vin = (i == 0 || i >= 3); t_din = int'($urandom_range(511)) - 256;
      step();
    end
    idle(3);
    chk("gap_pulses", seen.size(), 3);
    clear();
    seen.delete();
    sample(50);
    sample(60);
    t_clr = 1; t_vin = 1; t_din = 70; step();
    idle(3);
    chk("clr_pulses", seen.size(), 1);
    seen.delete();
    sample(255);
    idle(2);
    chk("clr_impulse", seen_at(0), 9);

    // Saturation, positive and negative step
    for (int i = 0; i < NTA; i++) set_coef(i, 64, 1'(i == NTA-1));
    foreach (hist[s]) if (s < 2) begin
      clear();
      seen.delete();
      t_vin = 1; t_din = (s == 0) ? 100 : -100;
      repeat (13) step();
      idle(2);
      chk("sat_first", seen_at(0),  (s == 0) ? 25  : -25);
      chk("sat_tenth", seen_at(9),  (s == 0) ? 250 : -250);
      chk("sat_clip",  seen_at(10), (s == 0) ? 255 : -256);
      chk("sat_hold",  seen_at(12), (s == 0) ? 255 : -256);
    end

    // Floor and saturation corners on a single tap
    for (int i = 0; i < NTA; i++) set_coef(i, 0, 1'(i == NTA-1));
    for (int k = 0; k < 7; k++) begin
      set_coef(0, corner[k].b0, 1'b1);
      clear();
      seen.delete();
      sample(corner[k].din);
      idle(2);
      chk("corner", seen_at(0), corner[k].exp);
    end

    // Commit timing, out-of-range writes, uncommitted shadow, write-through
    set_coef(0, 64, 1'b1);
    set_coef(0, 128, 1'b0);
    clear();
    seen.delete();
    t_vin = 1; t_din = 100; t_commit = 1; step(); t_commit = 0;
    sample(100);
    idle(2);
    chk("commit_old", seen_at(0), 25);
    chk("commit_new", seen_at(1), 50);
    for (int a = 11; a < 16; a++) set_coef(a, 200, 1'b0);
    t_commit = 1; step(); t_commit = 0;
    clear();
    seen.delete();
    sample(100);
    idle(2);
    chk("oob_write", seen_at(0), 50);
    set_coef(0, -256, 1'b0);
    clear();
    seen.delete();
    sample(100);
    idle(2);
    chk("shadow_only", seen_at(0), 50);
    set_coef(0, 32, 1'b1);
    clear();
    seen.delete();
    sample(100);
    idle(2);
    chk("write_through", seen_at(0), 12);

    // Random traffic against the model
    repeat (400) begin
      t_vin    = ($urandom_range(9) < 7);
      t_din    = int'($urandom_range(511)) - 256;
      t_clr    = ($urandom_range(19) == 0);
      t_we     = ($urandom_range(3) == 0);
      t_addr   = int'($urandom_range(15));
      t_cdin   = int'($urandom_range(511)) - 256;
      t_commit = ($urandom_range(9) == 0);
      step();
    end
    idle(2);

    // Asynchronous reset mid-stream
    set_coef(0, 100, 1'b1);
    t_vin = 1;
    repeat (3) begin t_din = int'($urandom_range(255)); step(); end
    t_din = 200;
    @(posedge clk);
    model_edge();
    #2 rst_n = 0;
    #1;
    chk("arst_dout", int'(a_dout), 0);
    chk("arst_vout", int'(a_vout), 0);
    model_reset();
    @(negedge clk);
    model_check();
    idle(1);
    rst_n = 1;
    seen.delete();
    sample(255);
    idle(2);
    chk("arst_pulses", seen.size(), 1);
    chk("arst_coef_zero", seen_at(0), 0);

    // 4-tap, 12-bit, 3-stage instance: impulse and latency
    for (int i = 0; i < 4; i++) begin
      b_we = 1; b_addr = i; b_cdin = 10*(i+1); b_commit = (i == 3);
      @(posedge clk); @(negedge clk);
    end
    b_we = 0; b_commit = 0;
    b_clr = 1; @(posedge clk); @(negedge clk); b_clr = 0;
    b_vin = 1; b_din = 2047;
    @(posedge clk); @(negedge clk);
    chk("b_vout_k", int'(b_vout), 0);
    b_din = 0;
    for (int j = 1; j <= 6; j++) begin
      if (j == 4) b_vin = 0;
      @(posedge clk); @(negedge clk);
      chk("b_vout", int'(b_vout), (j >= 3) ? 1 : 0);
      chk("b_dout", int'($signed(b_dout)), (j >= 3) ? b_exp[j-3] : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
